uart_tx_engine: RTL

UART transmit serializer that drains the TX byte FIFO and drives the serial line. It sits between the TX instance of the UART FIFO (read side) and the `txd` pad. It pops one byte at a time through the FIFO's registered read port and emits a complete asynchronous frame for each byte: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. Frame format and bit rate come from the UART line-control registers.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_cnt.sv | 45 ++++
 rtl/uart_tx_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and helpers: TX state encoding, data-length
//                codes and the data-length to bit-count mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Transmit engine states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

    // Line-control data_len field encodings
    localparam logic [1:0] DLEN_5 = 2'b00;
    localparam logic [1:0] DLEN_6 = 2'b01;
    localparam logic [1:0] DLEN_7 = 2'b10;
    localparam logic [1:0] DLEN_8 = 2'b11;

    // Number of data bits carried by a frame for a given data_len code
    function automatic logic [3:0] data_bits(input logic [1:0] len);
        logic [3:0] n;
        case (len)
            DLEN_5:  n = 4'd5;
            DLEN_6:  n = 4'd6;
            DLEN_7:  n = 4'd7;
            DLEN_8:  n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : 16-bit reloadable down-counter that times one bit period.
//                'tick' marks the terminal count (last cycle of the bit);
//                'pre_tick' says the terminal count is reached next cycle,
//                which lets users register decodes of the bit end.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_cnt (
    input  logic        clk,
    input  logic        rst_,
    input  logic        load,
    input  logic [15:0] baud_div,
    output logic        tick,
    output logic        pre_tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Reload on request, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = baud_div;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == 16'd0);
    assign pre_tick = (cnt_d == 16'd0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmit serializer. Pops bytes from the TX FIFO and
//                emits start / 5-8 data (LSB first) / optional parity /
//                1-2 stop bits on txd. All outputs are registered; each is
//                computed from the next-state values so it lines up with
//                the state it belongs to.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        tx_en,
    input  logic [15:0] baud_div,
    input  logic [1:0]  data_len,
    input  logic        stop2,
    input  logic        par_en,
    input  logic        par_even,
    input  logic        fifo_rempty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rinc,
    output logic        txd,
    output logic        tx_busy,
    output logic        tx_done
);

    tx_state_e   state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  nbits_q, nbits_d;
    logic        stop2_q, stop2_d;
    logic        par_en_q, par_en_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        rinc_q, rinc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        baud_load;
    logic        baud_tick;
    logic        baud_pre_tick;
    logic [7:0]  data_mask;

    // Keeps only the data bits that belong to the configured length
    assign data_mask = 8'hFF >> (4'd8 - data_bits(data_len));

    uart_baud_cnt u_baud_cnt (
        .clk      (clk),
        .rst_     (rst_),
        .load     (baud_load),
        .baud_div (baud_div),
        .tick     (baud_tick),
        .pre_tick (baud_pre_tick)
    );

    // Next-state, frame datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        nbits_d   = nbits_q;
        stop2_d   = stop2_q;
        par_en_d  = par_en_q;
        par_d     = par_q;
        baud_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_rempty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Freeze byte and format so later register writes cannot
                // disturb the frame in flight
                shreg_d   = fifo_data;
                nbits_d   = data_bits(data_len);
                stop2_d   = stop2;
                par_en_d  = par_en;
                par_d     = (^(fifo_data & data_mask)) ^ ~par_even;
                bitcnt_d  = 3'd0;
                baud_load = 1'b1;
                state_d   = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    shreg_d   = shreg_q >> 1;
                    if ({1'b0, bitcnt_q} == (nbits_q - 4'd1)) begin
                        bitcnt_d = 3'd0;
                        state_d  = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    bitcnt_d  = 3'd0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    if (bitcnt_q == {2'b00, stop2_q}) begin
                        bitcnt_d = 3'd0;
                        state_d  = (tx_en && !fifo_rempty) ? ST_FETCH : ST_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase

        rinc_d = (state_d == ST_FETCH);
        busy_d = (state_d != ST_IDLE);
        // Last cycle of the final stop bit is next cycle's terminal count
        done_d = (state_d == ST_STOP) && (bitcnt_d == {2'b00, stop2_q}) && baud_pre_tick;
    end

    // State, frame and output registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            shreg_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            nbits_q  <= 4'd8;
            stop2_q  <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            rinc_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            nbits_q  <= nbits_d;
            stop2_q  <= stop2_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            rinc_q   <= rinc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign txd       = txd_q;
    assign fifo_rinc = rinc_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule
`default_nettype wire
